// File: rtl/mac_8_pipe_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_8_pipe_responder                                            |
// | Brief    : 2-stage valid/ready pipelined out = a*b + c (WIDTH-bit result)  |
// |            Optional MAC_8_PIPE_SAT_EN selects unsigned saturation.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mac_8_pipe_responder #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [CNT_W-1:0] txn_cnt
);

   localparam int c_PW = 2 * WIDTH;

   logic              r_s1_valid;
   logic [c_PW-1:0]   r_s1_prod;
   logic [WIDTH-1:0]  r_s1_c;
   logic              r_s2_valid;
   logic [WIDTH-1:0]  r_out;
   logic [CNT_W-1:0]  r_txn_cnt;

   logic              w_s1_adv;
   logic              w_s2_adv;
   logic              w_in_fire;
   logic              w_out_fire;
   logic [c_PW:0]     w_sum;
   logic [WIDTH-1:0]  w_result;

   assign w_s2_adv   = !r_s2_valid || out_ready;
   assign w_s1_adv   = !r_s1_valid || w_s2_adv;
   assign w_in_fire  = in_valid && w_s1_adv;
   assign w_out_fire = r_s2_valid && out_ready;

   assign w_sum = {1'b0, r_s1_prod} + {{(c_PW + 1 - WIDTH){1'b0}}, r_s1_c};

`ifdef MAC_8_PIPE_SAT_EN
   assign w_result = (|w_sum[c_PW:WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
   assign w_result = w_sum[WIDTH-1:0];
`endif

   // Data regs load only on a real transfer so X on idle inputs never enters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_prod  <= '0;
         r_s1_c     <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_prod <= c_PW'(a) * c_PW'(b);
            r_s1_c    <= c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_out      <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out <= w_result;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txn_cnt <= '0;
      end else if (w_out_fire) begin
         r_txn_cnt <= r_txn_cnt + 1'b1;
      end
   end

   assign in_ready  = w_s1_adv;
   assign out_valid = r_s2_valid;
   assign out       = r_out;
   assign txn_cnt   = r_txn_cnt;

   logic w_unused;
   assign w_unused = w_in_fire;

endmodule
`default_nettype wire

// File: tb/tb_mac_8_pipe_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mac_8_pipe_responder                                         |
// | Brief    : Directed self-checking bench for mac_8_pipe_responder           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mac_8_pipe_responder;

   localparam int c_W  = 8;
   localparam int c_CW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [c_W-1:0]  a, b, c;
   logic            out_valid;
   logic            out_ready;
   logic [c_W-1:0]  out;
   logic [c_CW-1:0] txn_cnt;

   int checks = 0;
   int errors = 0;
   int nin    = 0;
   int nout   = 0;
   logic [c_W-1:0] q[$];

   mac_8_pipe_responder #(.WIDTH(c_W), .CNT_W(c_CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .txn_cnt   (txn_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [c_W-1:0] model(input logic [c_W-1:0] x, y, z);
      int s;
      s = int'(x) * int'(y) + int'(z);
`ifdef MAC_8_PIPE_SAT_EN
      if (s > 255) s = 255;
`endif
      return s[c_W-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Evaluate handshakes in the settled half of the cycle, then advance one clock.
   task automatic tick();
      logic [c_W-1:0] e;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'd0);
         end else begin
            e = q.pop_front();
            chk("scoreboard_out", 32'(out), 32'(e));
         end
         nout++;
      end
      if (in_valid && in_ready) begin
         q.push_back(model(a, b, c));
         nin++;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int n0, i0;
      logic [c_W-1:0] e2, held;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; c = '0;
      @(posedge clk); #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out", 32'(out), 32'd0);
      chk("reset_txn_cnt", 32'(txn_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // 1: 3*5+7 = 22, two cycles of latency
      a = 8'd3; b = 8'd5; c = 8'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
      tick();
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out", 32'(out), 32'd22);
      tick();
      chk("t1_txn_cnt", 32'(txn_cnt), 32'd1);

      // 2: 255*255+255 = 0xFF00 -> 0x00 wrap, 0xFF saturated
`ifdef MAC_8_PIPE_SAT_EN
      e2 = 8'hFF;
`else
      e2 = 8'h00;
`endif
      a = 8'd255; b = 8'd255; c = 8'd255; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      chk("t2_out", 32'(out), 32'(e2));
      tick();
      // X on idle inputs must not reach the output
      a = 'x; b = 'x; c = 'x;
      tick(); tick(); tick();
      chk("x_out_valid", 32'(out_valid), 32'd0);
      chk("x_out", 32'(out), 32'(e2));

      // 3: 100 back-to-back triples, one result per cycle
      do_reset();
      out_ready = 1'b1;
      n0 = nout;
      for (int k = 0; k < 100; k++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         c = 8'($urandom_range(0, 255));
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      chk("t3_results", 32'(nout - n0), 32'd100);
      chk("t3_queue_empty", 32'(q.size()), 32'd0);
      chk("t3_txn_cnt", 32'(txn_cnt), 32'd100);

      // 4: output stall fills both stages, then in_ready drops
      out_ready = 1'b0;
      i0 = nin;
      for (int k = 0; k < 5; k++) begin
         a = 8'(k + 10); b = 8'(k + 3); c = 8'(k);
         in_valid = 1'b1;
         if (k >= 2) begin
            chk("t4_in_ready_low", 32'(in_ready), 32'd0);
            chk("t4_out_valid_hold", 32'(out_valid), 32'd1);
            chk("t4_out_hold", 32'(out), 32'(held));
         end
         tick();
         if (k == 1) held = q[0];
      end
      chk("t4_accepts", 32'(nin - i0), 32'd2);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 10 && q.size() > 0; k++) tick();
      chk("t4_drained", 32'(q.size()), 32'd0);
      chk("t4_txn_cnt", 32'(txn_cnt), 32'd102);

      // 5: async reset with two items in flight
      out_ready = 1'b0;
      a = 8'd9; b = 8'd9; c = 8'd9; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_txn_cnt", 32'(txn_cnt), 32'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      tick();
      chk("t5_idle_after_rst", 32'(out_valid), 32'd0);
      a = 8'd2; b = 8'd2; c = 8'd1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t5_latency", 32'(out_valid), 32'd0);
      tick();
      chk("t5_out_valid", 32'(out_valid), 32'd1);
      chk("t5_out", 32'(out), 32'd5);
      tick();

      // 6: counter wrap after 65535 + 1 handshakes
      do_reset();
      out_ready = 1'b1;
      a = 8'd1; b = 8'd1; c = 8'd0;
      n0 = nout; i0 = nin;
      for (int k = 0; k < 70000; k++) begin
         if (nout - n0 >= 65535) break;
         in_valid = (nin - i0) < 65535;
         tick();
      end
      in_valid = 1'b0;
      chk("t6_count_reached", 32'(nout - n0), 32'd65535);
      chk("t6_txn_ffff", 32'(txn_cnt), 32'hFFFF);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("t6_txn_wrap", 32'(txn_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
